// File: rtl/pio_irq_servicer.sv
// pio_irq_servicer: writes the PIO interrupt mask once after reset. On each
// enabled PIO interrupt it reads and clears edge_capture, samples the data
// register and presents the result as a valid/ready event.
module pio_irq_servicer #(
   parameter int             DW        = 32,
   parameter logic [DW-1:0]  MASK_INIT = {{(DW-1){1'b0}}, 1'b1}
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic           pio_irq,
   output logic           pio_chipselect,
   output logic [1:0]     pio_address,
   output logic           pio_write_n,
   output logic [DW-1:0]  pio_writedata,
   input  logic [DW-1:0]  pio_readdata,
   output logic           evt_valid,
   input  logic           evt_ready,
   output logic [DW-1:0]  evt_capture,
   output logic [DW-1:0]  evt_level,
   output logic [15:0]    evt_count,
   output logic           busy
);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   typedef enum logic [2:0] {
      INIT, IDLE, RD_CAP, WT_CAP, CLR, RD_DAT, WT_DAT, PUSH
   } state_t;

   state_t          state_reg, state_next;
   logic            bus_cs, bus_wn;
   logic [1:0]      bus_addr;
   logic [DW-1:0]   bus_wd;
   logic [DW-1:0]   capture_reg, level_reg;
   logic [15:0]     count_reg;

   // State register; reset parks in INIT so the mask write is redone after every reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= INIT;
      else       state_reg <= state_next;
   end

   // Next-state and bus decode. Read data arrives one cycle after the read
   // strobe, hence the WT_* states in which the value is consumed.
   always_comb begin
      state_next = state_reg;
      bus_cs     = 1'b0;
      bus_wn     = 1'b1;
      bus_addr   = ADDR_DATA;
      bus_wd     = '0;
      case (state_reg)
         INIT: begin
            bus_cs     = 1'b1;
            bus_wn     = 1'b0;
            bus_addr   = ADDR_MASK;
            bus_wd     = MASK_INIT;
            state_next = IDLE;
         end
         IDLE: begin
            if (pio_irq && enable) state_next = RD_CAP;
         end
         RD_CAP: begin
            bus_cs     = 1'b1;
            bus_addr   = ADDR_EDGE;
            state_next = WT_CAP;
         end
         WT_CAP: begin
            // An all-zero capture means the interrupt was spurious: nothing to clear or report.
            state_next = (pio_readdata == '0) ? IDLE : CLR;
         end
         CLR: begin
            bus_cs     = 1'b1;
            bus_wn     = 1'b0;
            bus_addr   = ADDR_EDGE;
            bus_wd     = '1;
            state_next = RD_DAT;
         end
         RD_DAT: begin
            bus_cs     = 1'b1;
            bus_addr   = ADDR_DATA;
            state_next = WT_DAT;
         end
         WT_DAT: begin
            state_next = PUSH;
         end
         PUSH: begin
            // Always returns through IDLE so pio_irq has time to reflect the clear.
            if (evt_ready) state_next = IDLE;
         end
         default: state_next = INIT;
      endcase
   end

   // Bus outputs are forced idle while reset is held, even though the state is INIT.
   always_comb begin
      pio_chipselect = bus_cs & ~reset;
      pio_write_n    = bus_wn | reset;
      pio_address    = reset ? ADDR_DATA : bus_addr;
      pio_writedata  = reset ? '0 : bus_wd;
   end

   // Event payload capture and accepted-event counter (wraps naturally at 16 bits).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         capture_reg <= '0;
         level_reg   <= '0;
         count_reg   <= '0;
      end else begin
         if (state_reg == WT_CAP) capture_reg <= pio_readdata;
         if (state_reg == WT_DAT) level_reg   <= pio_readdata;
         if (state_reg == PUSH && evt_ready) count_reg <= count_reg + 16'd1;
      end
   end

   assign evt_valid   = (state_reg == PUSH);
   assign evt_capture = capture_reg;
   assign evt_level   = level_reg;
   assign evt_count   = count_reg;
   assign busy        = (state_reg != IDLE);

endmodule
